amber_wb_inst_feeder: RTL and testbench

- Wishbone slave that sequences instructions into the Amber25 core's 128-bit instruction/data bus during directed verification.
- The bench pushes 32-bit instruction words into an internal FIFO. Each core read cycle pops one word and returns it replicated across all four 32-bit lanes.
- When the FIFO is empty, a read returns a configurable NOP.
- Write cycles are acknowledged, and the selected lane is exposed as a store-capture pulse for the scoreboard.

---
 rtl/amber_wb_inst_feeder.sv | 118 +++++++++++
 tb/tb_amber_wb_inst_feeder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/amber_wb_inst_feeder.sv
// Wishbone slave feeding queued instruction words (x4 lanes) to the core, NOP when empty; stores captured.
// Latency: request sampled at edge N, ack/err for one cycle after it; push backpressure is o_push_ready = not-full.
module amber_wb_inst_feeder #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push_valid,
    input  logic [31:0]  i_push_data,
    output logic         o_push_ready,
    input  logic [31:0]  i_wb_adr,
    input  logic [15:0]  i_wb_sel,
    input  logic         i_wb_we,
    input  logic [127:0] i_wb_dat,
    output logic [127:0] o_wb_dat,
    input  logic         i_wb_cyc,
    input  logic         i_wb_stb,
    output logic         o_wb_ack,
    output logic         o_wb_err,
    output logic         o_st_valid,
    output logic [31:0]  o_st_adr,
    output logic [31:0]  o_st_data,
    output logic [15:0]  o_fetch_count,
    output logic [15:0]  o_nop_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RESP} state_t;

    state_t         state;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           full;
    logic           empty;
    logic           req;
    logic           push_en;
    logic           pop_en;
    logic [31:0]    st_lane;

    assign full         = (count == (AW+1)'(DEPTH));
    assign empty        = (count == '0);
    assign o_push_ready = ~full;
    assign req          = (state == IDLE) && i_wb_cyc && i_wb_stb;
    // No bypass: fullness is judged before any same-cycle pop.
    assign push_en      = i_push_valid && !full;
    assign pop_en       = req && !i_wb_we && !empty;

    always_comb begin
        st_lane = i_wb_dat[31:0];
        case (i_wb_adr[3:2])
            2'd0: st_lane = i_wb_dat[31:0];
            2'd1: st_lane = i_wb_dat[63:32];
            2'd2: st_lane = i_wb_dat[95:64];
            2'd3: st_lane = i_wb_dat[127:96];
            default: st_lane = i_wb_dat[31:0];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push_en) mem[wr_ptr] <= i_push_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_wb_dat      <= '0;
            o_wb_ack      <= 1'b0;
            o_wb_err      <= 1'b0;
            o_st_valid    <= 1'b0;
            o_st_adr      <= '0;
            o_st_data     <= '0;
            o_fetch_count <= '0;
            o_nop_count   <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};

            case (state)
                IDLE: begin
                    if (req) begin
                        state <= RESP;
                        if (!i_wb_we) begin
                            o_wb_ack <= 1'b1;
                            if (!empty) begin
                                o_wb_dat <= {4{mem[rd_ptr]}};
                                if (o_fetch_count != 16'hFFFF) o_fetch_count <= o_fetch_count + 16'd1;
                            end else begin
                                o_wb_dat <= {4{NOP_WORD}};
                                if (o_nop_count != 16'hFFFF) o_nop_count <= o_nop_count + 16'd1;
                            end
                        end else if (|i_wb_sel) begin
                            o_wb_ack   <= 1'b1;
                            o_st_valid <= 1'b1;
                            o_st_adr   <= i_wb_adr;
                            o_st_data  <= st_lane;
                        end else begin
                            o_wb_err <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    o_wb_ack   <= 1'b0;
                    o_wb_err   <= 1'b0;
                    o_st_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_amber_wb_inst_feeder.sv
`timescale 1ns/1ps
module tb_amber_wb_inst_feeder;
    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'hE1A00000;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_push_valid;
    logic [31:0]  i_push_data;
    logic         o_push_ready;
    logic [31:0]  i_wb_adr;
    logic [15:0]  i_wb_sel;
    logic         i_wb_we;
    logic [127:0] i_wb_dat;
    logic [127:0] o_wb_dat;
    logic         i_wb_cyc;
    logic         i_wb_stb;
    logic         o_wb_ack;
    logic         o_wb_err;
    logic         o_st_valid;
    logic [31:0]  o_st_adr;
    logic [31:0]  o_st_data;
    logic [15:0]  o_fetch_count;
    logic [15:0]  o_nop_count;

    amber_wb_inst_feeder #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_push_valid(i_push_valid), .i_push_data(i_push_data), .o_push_ready(o_push_ready),
        .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat),
        .o_wb_dat(o_wb_dat), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
        .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_st_valid(o_st_valid), .o_st_adr(o_st_adr), .o_st_data(o_st_data),
        .o_fetch_count(o_fetch_count), .o_nop_count(o_nop_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic [127:0] dat;
        logic         exp_ack;
        logic         exp_err;
        logic         exp_stv;
        logic [31:0]  exp_std;
    } wvec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] q[$];
    int          fetch_m  = 0;
    int          nop_m    = 0;
    wvec_t       nov;
    wvec_t       wtab[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One bench cycle: optional push and/or bus request; response checked in the following cycle.
    task automatic cycle_req(input logic do_push, input logic [31:0] pdata, input logic do_req,
                             input logic we, input logic [31:0] adr, input logic [15:0] sel,
                             input logic [127:0] wdat, input logic use_tab, input wvec_t tv);
        logic         full_m;
        logic [127:0] exp_dat;
        logic         e_ack, e_err, e_stv;
        logic [31:0]  e_std;
        logic [127:0] shifted;
        check("push_ready", o_push_ready, q.size() < DEPTH);
        full_m = (q.size() == DEPTH);
        i_push_valid = do_push; i_push_data = pdata;
        i_wb_cyc = do_req; i_wb_stb = do_req; i_wb_we = we;
        i_wb_adr = adr; i_wb_sel = sel; i_wb_dat = wdat;
        e_ack = 0; e_err = 0; e_stv = 0; e_std = '0; exp_dat = '0;
        if (do_req) begin
            if (!we) begin
                e_ack = 1;
                if (q.size() > 0) begin
                    exp_dat = {4{q.pop_front()}};
                    if (fetch_m < 65535) fetch_m++;
                end else begin
                    exp_dat = {4{NOP}};
                    if (nop_m < 65535) nop_m++;
                end
            end else if (use_tab) begin
                e_ack = tv.exp_ack; e_err = tv.exp_err; e_stv = tv.exp_stv; e_std = tv.exp_std;
            end else begin
                shifted = wdat >> (32 * int'(adr[3:2]));
                e_ack = (sel != 0); e_err = (sel == 0); e_stv = (sel != 0); e_std = shifted[31:0];
            end
        end
        if (do_push && !full_m) q.push_back(pdata);
        @(posedge i_clk); @(negedge i_clk);
        i_push_valid = 0; i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
        if (do_req) begin
            check("ack", o_wb_ack, e_ack);
            check("err", o_wb_err, e_err);
            check("st_valid", o_st_valid, e_stv);
            if (!we) check("rd_dat", o_wb_dat, exp_dat);
            if (e_stv) begin
                check("st_adr", o_st_adr, adr);
                check("st_data", o_st_data, e_std);
            end
            check("fetch_count", o_fetch_count, fetch_m[15:0]);
            check("nop_count", o_nop_count, nop_m[15:0]);
            @(posedge i_clk); @(negedge i_clk);
            check("resp_one_cycle", {o_wb_ack, o_wb_err, o_st_valid}, 3'b000);
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        cycle_req(1, d, 0, 0, '0, '0, '0, 0, nov);
    endtask

    task automatic read_req();
        cycle_req(0, '0, 1, 0, '0, '0, '0, 0, nov);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nov = '{default: '0};
        wtab[0] = '{32'h0000_1008, 16'h0F00, 128'hDEADBEEF_CAFEF00D_12345678_0BADC0DE, 1, 0, 1, 32'hCAFEF00D};
        wtab[1] = '{32'h0000_1000, 16'h000F, 128'hDEADBEEF_CAFEF00D_12345678_0BADC0DE, 1, 0, 1, 32'h0BADC0DE};
        wtab[2] = '{32'h0000_2004, 16'h00F0, 128'hDEADBEEF_CAFEF00D_12345678_0BADC0DE, 1, 0, 1, 32'h12345678};
        wtab[3] = '{32'h0000_300C, 16'hF000, 128'hDEADBEEF_CAFEF00D_12345678_0BADC0DE, 1, 0, 1, 32'hDEADBEEF};
        wtab[4] = '{32'h0000_1008, 16'h0000, 128'hDEADBEEF_CAFEF00D_12345678_0BADC0DE, 0, 1, 0, 32'h0};
        wtab[5] = '{32'h0000_400C, 16'h0001, 128'h89ABCDEF_CAFEF00D_12345678_0BADC0DE, 1, 0, 1, 32'h89ABCDEF};

        i_rst = 1; i_push_valid = 0; i_push_data = '0; i_wb_adr = '0; i_wb_sel = '0;
        i_wb_we = 0; i_wb_dat = '0; i_wb_cyc = 0; i_wb_stb = 0;
        #12;
        check("rst_ack", o_wb_ack, 1'b0);
        check("rst_err", o_wb_err, 1'b0);
        check("rst_st_valid", o_st_valid, 1'b0);
        check("rst_st_adr", o_st_adr, 32'h0);
        check("rst_st_data", o_st_data, 32'h0);
        check("rst_wb_dat", o_wb_dat, 128'h0);
        check("rst_counts", {o_fetch_count, o_nop_count}, 32'h0);
        check("rst_push_ready", o_push_ready, 1'b1);
        @(negedge i_clk); i_rst = 0;

        push_word(32'h11111111); push_word(32'h22222222); push_word(32'h33333333);
        repeat (3) read_req();
        read_req();

        // Fill, overfill, then push+pop while full (push must be dropped).
        for (int i = 0; i < DEPTH; i++) push_word(32'hA000_0000 + i);
        push_word(32'hBADBAD00);
        cycle_req(1, 32'hBADBAD01, 1, 0, '0, '0, '0, 0, nov);
        for (int i = 0; i < DEPTH; i++) read_req();

        for (int i = 0; i < 6; i++)
            cycle_req(0, '0, 1, 1, wtab[i].adr, wtab[i].sel, wtab[i].dat, 1, wtab[i]);

        // Asynchronous reset while a response is on the bus.
        for (int i = 0; i < 4; i++) push_word(32'hC000_0000 + i);
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0;
        @(posedge i_clk); @(negedge i_clk);
        check("pre_rst_ack", o_wb_ack, 1'b1);
        #2 i_rst = 1;
        #1;
        check("async_rst_ack", o_wb_ack, 1'b0);
        check("async_rst_counts", {o_fetch_count, o_nop_count}, 32'h0);
        check("async_rst_push_ready", o_push_ready, 1'b1);
        i_wb_cyc = 0; i_wb_stb = 0;
        q.delete(); fetch_m = 0; nop_m = 0;
        @(negedge i_clk); i_rst = 0;
        read_req();

        for (int n = 0; n < 400; n++) begin
            int          op;
            logic [15:0] s;
            op = $urandom_range(0, 3);
            s  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            case (op)
                0: push_word($urandom);
                1: read_req();
                2: cycle_req(0, '0, 1, 1, $urandom, s, {$urandom, $urandom, $urandom, $urandom}, 0, nov);
                default: cycle_req(1, $urandom, 1, 0, '0, '0, '0, 0, nov);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
